// File: rtl/bcd_seg_scan_if.sv
// Display-side bus for bcd_seg_scan: BCD digits and wrap pulse in,
// active-low anode/segment/decimal-point drive out.
interface bcd_seg_scan_if;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic       cout;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output BCD1, BCD0, cout, blank_lz,
    input  an, seg, dp
  );

  modport slave (
    input  BCD1, BCD0, cout, blank_lz,
    output an, seg, dp
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed 7-segment driver for the BCD counter: per-frame digit
// snapshot, optional leading-zero blanking and a stretched wrap indicator on dp.
module bcd_seg_scan #(
  parameter int SCAN_DIV  = 16,
  parameter int FLASH_CYC = 64
) (
  input  logic          clk,
  input  logic          reset,
  bcd_seg_scan_if.slave bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STR_W = $clog2(FLASH_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(FLASH_CYC);

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } sel_e;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  sel_e             sel_q, sel_d;
  logic [3:0]       snap1_q, snap1_d;
  logic [3:0]       snap0_q, snap0_d;
  logic [STR_W-1:0] stretch_q, stretch_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_s;

  // Next-state for divider, digit select, snapshot, stretch and output drive.
  always_comb begin
    tick_s    = (div_q == DIV_LAST);
    div_d     = tick_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    sel_d     = sel_q;
    snap1_d   = snap1_q;
    snap0_d   = snap0_q;
    stretch_d = stretch_q;
    an_d      = 4'b1111;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;

    case (sel_q)
      DIG0: begin
        if (tick_s) begin
          sel_d = DIG1;
        end else begin
          sel_d = DIG0;
        end
        an_d  = 4'b1110;
        seg_d = dec7(snap0_q);
        dp_d  = (stretch_q != {STR_W{1'b0}}) ? 1'b0 : 1'b1;
      end
      DIG1: begin
        // Leaving DIG1 starts a new frame, so the digits are captured here only.
        if (tick_s) begin
          sel_d   = DIG0;
          snap1_d = bus.BCD1;
          snap0_d = bus.BCD0;
        end else begin
          sel_d = DIG1;
        end
        an_d = 4'b1101;
        if (bus.blank_lz && (snap1_q == 4'd0)) begin
          seg_d = 7'h7F;
        end else begin
          seg_d = dec7(snap1_q);
        end
        dp_d = 1'b1;
      end
      default: begin
        sel_d = DIG0;
      end
    endcase

    if (bus.cout) begin
      stretch_d = STR_LOAD;
    end else if (stretch_q != {STR_W{1'b0}}) begin
      stretch_d = stretch_q - STR_W'(1);
    end else begin
      stretch_d = {STR_W{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q     <= {DIV_W{1'b0}};
      sel_q     <= DIG0;
      snap1_q   <= 4'd0;
      snap0_q   <= 4'd0;
      stretch_q <= {STR_W{1'b0}};
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      div_q     <= div_d;
      sel_q     <= sel_d;
      snap1_q   <= snap1_d;
      snap0_q   <= snap0_d;
      stretch_q <= stretch_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan (SCAN_DIV=4, FLASH_CYC=8): cycle-exact
// vector table plus short reset/pulse sequences.
module tb_bcd_seg_scan;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(
    .SCAN_DIV (4),
    .FLASH_CYC(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] b1;
    logic [3:0] b0;
    logic       co;
    logic       blz;
    int         n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] b1, input logic [3:0] b0,
                     input logic co, input logic blz, input int n,
                     input logic [3:0] an, input logic [6:0] seg, input logic dp);
    vec_t v;
    v.rst = rst; v.b1 = b1; v.b0 = b0; v.co = co; v.blz = blz; v.n = n;
    v.an = an; v.seg = seg; v.dp = dp;
    tbl.push_back(v);
  endtask

  task automatic step(input logic rst, input logic [3:0] b1, input logic [3:0] b0,
                      input logic co, input logic blz);
    @(negedge clk);
    reset        = rst;
    bus.BCD1     = b1;
    bus.BCD0     = b0;
    bus.cout     = co;
    bus.blank_lz = blz;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [3:0] an,
                       input logic [6:0] seg, input logic dp);
    n_cmp++;
    if ({bus.an, bus.seg, bus.dp} !== {an, seg, dp}) begin
      n_bad++;
      $display("FAIL %s cyc%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, cyc, bus.an, bus.seg, bus.dp, an, seg, dp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b0;
    bus.BCD1 = 4'd0; bus.BCD0 = 4'd0; bus.cout = 1'b0; bus.blank_lz = 1'b0;

    // rst b1 b0 co blz n      an     seg    dp
    add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2, 4'hF, 7'h7F, 1'b1); // reset held
    add(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1, 4'hE, 7'h40, 1'b1); // first edge after release
    add(1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 3, 4'hE, 7'h40, 1'b1);
    add(1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 4, 4'hD, 7'h40, 1'b1); // unblanked zero tens
    add(1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 4, 4'hE, 7'h24, 1'b1);
    add(1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 4, 4'hD, 7'h19, 1'b1);
    add(1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 1, 4'hE, 7'h24, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 3, 4'hE, 7'h24, 1'b1); // 57 arrives mid-DIG0
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 4, 4'hD, 7'h19, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 4, 4'hE, 7'h78, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 4, 4'hD, 7'h12, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b1, 1'b0, 1, 4'hE, 7'h78, 1'b1); // single cout pulse
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 3, 4'hE, 7'h78, 1'b0);
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 4, 4'hD, 7'h12, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 1, 4'hE, 7'h78, 1'b0); // 8th cycle after pulse
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 3, 4'hE, 7'h78, 1'b1); // expired
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 4, 4'hD, 7'h12, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b1, 1'b0, 1, 4'hE, 7'h78, 1'b1); // first of two pulses
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 3, 4'hE, 7'h78, 1'b0);
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 1, 4'hD, 7'h12, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b1, 1'b0, 1, 4'hD, 7'h12, 1'b1); // retrigger 5 later
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 2, 4'hD, 7'h12, 1'b1);
    add(1'b1, 4'd5, 4'd7, 1'b0, 1'b0, 4, 4'hE, 7'h78, 1'b0); // held only by reload
    add(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 4, 4'hD, 7'h12, 1'b1);
    add(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 4, 4'hE, 7'h12, 1'b1);
    add(1'b1, 4'd0, 4'd5, 1'b0, 1'b1, 3, 4'hD, 7'h7F, 1'b1); // blanked leading zero
    add(1'b1, 4'hA, 4'd0, 1'b0, 1'b1, 1, 4'hD, 7'h7F, 1'b1);
    add(1'b1, 4'hA, 4'd0, 1'b0, 1'b1, 4, 4'hE, 7'h40, 1'b1);
    add(1'b1, 4'hA, 4'd0, 1'b0, 1'b1, 1, 4'hD, 7'h3F, 1'b1); // invalid tens -> dash
    add(1'b1, 4'hA, 4'd0, 1'b1, 1'b1, 1, 4'hD, 7'h3F, 1'b1); // arm stretch mid-DIG1
    add(1'b0, 4'hA, 4'd0, 1'b0, 1'b0, 1, 4'hF, 7'h7F, 1'b1); // reset mid-DIG1
    add(1'b1, 4'hA, 4'd0, 1'b0, 1'b0, 4, 4'hE, 7'h40, 1'b1); // restart, no dp
    add(1'b1, 4'hA, 4'd0, 1'b0, 1'b0, 4, 4'hD, 7'h40, 1'b1);
    add(1'b1, 4'hA, 4'd0, 1'b0, 1'b0, 4, 4'hE, 7'h40, 1'b1);
    add(1'b1, 4'hA, 4'd0, 1'b0, 1'b0, 1, 4'hD, 7'h3F, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].rst, tbl[i].b1, tbl[i].b0, tbl[i].co, tbl[i].blz);
        check($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].dp);
      end
    end

    // Reset coinciding with a cout pulse must leave the stretch cleared.
    step(1'b0, 4'd9, 4'd9, 1'b1, 1'b0);
    check("rst_vs_cout", 4'hF, 7'h7F, 1'b1);
    step(1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    check("post_rst_0", 4'hE, 7'h40, 1'b1);
    step(1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    check("post_rst_1", 4'hE, 7'h40, 1'b1);

    // A pulse held for consecutive cycles keeps reloading; dp tracks DIG0 only.
    step(1'b1, 4'd9, 4'd9, 1'b1, 1'b0);
    check("cout_hold_0", 4'hE, 7'h40, 1'b1);
    step(1'b1, 4'd9, 4'd9, 1'b1, 1'b0);
    check("cout_hold_1", 4'hE, 7'h40, 1'b0);
    step(1'b1, 4'd9, 4'd9, 1'b0, 1'b0);
    check("cout_dig1", 4'hD, 7'h40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
